uart_monitor: RTL and testbench

- Parametrised boot/debug monitor between the UART core, the shared RAM and the CPU.
- Decodes framed host commands: LOAD, DUMP, FILL and EXEC.
- Owns the RAM and UART ports while the CPU is stopped, and returns ownership to the CPU on EXEC.
- Regains control on CPU halt.
- Adds to the previous monitor:
  - width-generic addressing and 16-bit lengths;
  - FILL;
  - ACK/NAK + checksum responses;
  - receive timeout.

---
 rtl/uart_monitor_pkg.sv | 31 +++
 rtl/uart_monitor_tx_sequencer.sv | 30 +++
 rtl/uart_monitor.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_monitor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_monitor_pkg.sv
// Shared definitions for the UART boot/debug monitor: wire command codes,
// response bytes, the controller state set and the address-byte count helper.
package uart_monitor_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h01;
  localparam logic [7:0] CMD_DUMP = 8'h02;
  localparam logic [7:0] CMD_FILL = 8'h03;
  localparam logic [7:0] CMD_EXEC = 8'h04;

  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_FILL,
    ST_DUMP_RD,
    ST_DUMP_TX,
    ST_EXEC,
    ST_RUN,
    ST_ACK,
    ST_SUM,
    ST_NAK
  } state_t;

  function automatic int addr_bytes(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_monitor_tx_sequencer.sv
// Single-pulse UART transmit launcher: accepts a requested byte only when the
// UART is idle and no pulse went out on the previous clock.
module tx_sequencer
  import uart_monitor_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic [7:0] req_byte,
  input  logic       tx_busy,
  output logic       accept,
  output logic       tx_start,
  output logic [7:0] tx_byte
);

  // The UART raises busy one clock after tx_start, so the previous pulse
  // must also block a new send.
  assign accept = req & ~tx_busy & ~tx_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_byte  <= 8'h00;
    end else begin
      tx_start <= accept;
      if (accept) tx_byte <= req_byte;
    end
  end

endmodule

// File: rtl/uart_monitor.sv
// Boot/debug monitor: decodes LOAD/DUMP/FILL/EXEC frames from the UART, owns
// RAM and UART while the CPU is stopped and hands them over on EXEC.
module uart_monitor
  import uart_monitor_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 12000000,
  parameter int RESET_CYCLES   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_byte,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_byte,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [7:0]            mem_rdata,
  output logic                  mon_owns,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] cpu_startaddr,
  input  logic                  cpu_halted
);

  localparam int AB = addr_bytes(ADDR_WIDTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  state_t                state;
  logic [7:0]            cmd;
  logic [7:0]            fill_val;
  logic [7:0]            sum;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  len_next;
  logic [3:0]            idx;
  logic [TW-1:0]         idle;
  logic [RW-1:0]         rcnt;
  logic                  req;
  logic                  accept;
  logic [7:0]            req_byte;

  // Shifting a byte in from the bottom drops address bits above ADDR_WIDTH.
  assign addr_next = ADDR_WIDTH'({addr, rx_byte});
  assign len_next  = LEN_WIDTH'({len, rx_byte});

  function automatic logic [3:0] hdr_last(input logic [7:0] c);
    case (c)
      CMD_EXEC: return 4'(AB - 1);
      CMD_FILL: return 4'(AB + 2);
      default:  return 4'(AB + 1);
    endcase
  endfunction

  always_comb begin
    req      = 1'b0;
    req_byte = mem_rdata;
    case (state)
      ST_DUMP_TX: req = 1'b1;
      ST_ACK: begin
        req      = 1'b1;
        req_byte = ACK_BYTE;
      end
      ST_SUM: begin
        req      = 1'b1;
        req_byte = sum;
      end
      ST_NAK: begin
        req      = 1'b1;
        req_byte = NAK_BYTE;
      end
      default: ;
    endcase
  end

  tx_sequencer u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_byte (req_byte),
    .tx_busy  (tx_busy),
    .accept   (accept),
    .tx_start (tx_start),
    .tx_byte  (tx_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cmd           <= 8'h00;
      fill_val      <= 8'h00;
      sum           <= 8'h00;
      addr          <= '0;
      len           <= '0;
      idx           <= 4'd0;
      idle          <= '0;
      rcnt          <= '0;
      mem_we        <= 1'b0;
      mem_waddr     <= '0;
      mem_wdata     <= 8'h00;
      mem_raddr     <= '0;
      mon_owns      <= 1'b1;
      cpu_reset     <= 1'b0;
      cpu_startaddr <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          idle <= '0;
          if (rx_valid) begin
            cmd  <= rx_byte;
            idx  <= 4'd0;
            addr <= '0;
            len  <= '0;
            sum  <= 8'h00;
            if (rx_byte inside {CMD_LOAD, CMD_DUMP, CMD_FILL, CMD_EXEC}) state <= ST_HDR;
            else state <= ST_NAK;
          end
        end

        ST_HDR: begin
          if (rx_valid) begin
            idle <= '0;
            idx  <= idx + 4'd1;
            if (idx < 4'(AB)) addr <= addr_next;
            else if (idx < 4'(AB + 2)) len <= len_next;
            else fill_val <= rx_byte;
            if (idx == hdr_last(cmd)) begin
              case (cmd)
                CMD_LOAD: state <= (len_next == '0) ? ST_ACK : ST_LOAD;
                CMD_DUMP: begin
                  mem_raddr <= addr;
                  state     <= (len_next == '0) ? ST_ACK : ST_DUMP_RD;
                end
                CMD_FILL: state <= (len == '0) ? ST_ACK : ST_FILL;
                CMD_EXEC: begin
                  cpu_startaddr <= addr_next;
                  mon_owns      <= 1'b0;
                  cpu_reset     <= 1'b1;
                  rcnt          <= RW'(RESET_CYCLES - 1);
                  state         <= ST_EXEC;
                end
                default: state <= ST_NAK;
              endcase
            end
          end else if (idle == TW'(TIMEOUT_CYCLES - 1)) begin
            idle  <= '0;
            sum   <= 8'h00;
            state <= ST_NAK;
          end else begin
            idle <= idle + TW'(1);
          end
        end

        ST_LOAD: begin
          if (rx_valid) begin
            idle      <= '0;
            mem_we    <= 1'b1;
            mem_waddr <= addr;
            mem_wdata <= rx_byte;
            sum       <= sum + rx_byte;
            addr      <= addr + ADDR_WIDTH'(1);
            len       <= len - LEN_WIDTH'(1);
            if (len == LEN_WIDTH'(1)) state <= ST_ACK;
          end else if (idle == TW'(TIMEOUT_CYCLES - 1)) begin
            // Writes already made stay in RAM; only the checksum is dropped.
            idle  <= '0;
            sum   <= 8'h00;
            state <= ST_NAK;
          end else begin
            idle <= idle + TW'(1);
          end
        end

        ST_FILL: begin
          mem_we    <= 1'b1;
          mem_waddr <= addr;
          mem_wdata <= fill_val;
          sum       <= sum + fill_val;
          addr      <= addr + ADDR_WIDTH'(1);
          len       <= len - LEN_WIDTH'(1);
          if (len == LEN_WIDTH'(1)) state <= ST_ACK;
        end

        // mem_rdata follows mem_raddr by one clock.
        ST_DUMP_RD: state <= ST_DUMP_TX;

        ST_DUMP_TX: begin
          if (accept) begin
            sum       <= sum + mem_rdata;
            addr      <= addr + ADDR_WIDTH'(1);
            mem_raddr <= addr + ADDR_WIDTH'(1);
            len       <= len - LEN_WIDTH'(1);
            state     <= (len == LEN_WIDTH'(1)) ? ST_ACK : ST_DUMP_RD;
          end
        end

        ST_EXEC: begin
          if (rcnt == '0) begin
            cpu_reset <= 1'b0;
            state     <= ST_RUN;
          end else begin
            rcnt <= rcnt - RW'(1);
          end
        end

        ST_RUN: begin
          if (cpu_halted) begin
            mon_owns <= 1'b1;
            sum      <= 8'h00;
            state    <= ST_ACK;
          end
        end

        ST_ACK: if (accept) state <= ST_SUM;

        ST_SUM: begin
          if (accept) begin
            sum   <= 8'h00;
            state <= ST_IDLE;
          end
        end

        ST_NAK: if (accept) state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_monitor.sv
// Randomized bench for uart_monitor: a UART/RAM environment plus a frame-level
// reference model of RAM contents and expected response bytes.
module tb_uart_monitor;

  localparam int AW  = 12;
  localparam int TO  = 100;
  localparam int MEM = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          tx_busy = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_byte;
  logic [AW-1:0] mem_waddr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [AW-1:0] mem_raddr;
  logic [7:0]    mem_rdata;
  logic          mon_owns;
  logic          cpu_reset;
  logic [AW-1:0] cpu_startaddr;
  logic          cpu_halted = 1'b0;

  always #5 clk = ~clk;

  uart_monitor #(
    .ADDR_WIDTH     (AW),
    .LEN_WIDTH      (16),
    .TIMEOUT_CYCLES (TO),
    .RESET_CYCLES   (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_valid      (rx_valid),
    .rx_byte       (rx_byte),
    .tx_busy       (tx_busy),
    .tx_start      (tx_start),
    .tx_byte       (tx_byte),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_raddr     (mem_raddr),
    .mem_rdata     (mem_rdata),
    .mon_owns      (mon_owns),
    .cpu_reset     (cpu_reset),
    .cpu_startaddr (cpu_startaddr),
    .cpu_halted    (cpu_halted)
  );

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] ram[MEM];
  logic [7:0] ref_ram[MEM];
  logic [7:0] tx_q[$];
  int         wlog_addr[$];
  int         wlog_cyc[$];
  int         wr_cnt = 0;
  int         rst_hi = 0;
  int         busy_left = 0;
  bit         uart_act = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    mem_rdata <= ram[mem_raddr];
  end

  // UART raises busy one clock after tx_start; RAM writes land at negedge.
  always @(negedge clk) begin
    if (tx_start) begin
      check("tx_while_uart_active", uart_act, 1'b0);
      tx_q.push_back(tx_byte);
      uart_act  = 1'b1;
      busy_left = $urandom_range(2, 8);
    end else if (uart_act) begin
      tx_busy = 1'b1;
      busy_left--;
      if (busy_left == 0) begin
        uart_act = 1'b0;
        tx_busy  = 1'b0;
      end
    end
    if (mem_we) begin
      ram[mem_waddr] = mem_wdata;
      wr_cnt++;
      wlog_addr.push_back(int'(mem_waddr));
      wlog_cyc.push_back(cyc);
    end
    if (cpu_reset) rst_hi++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_byte  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat ($urandom_range(0, 4)) @(posedge clk);
  endtask

  task automatic expect_resp(input string tag, input logic [7:0] exp[$]);
    int t = 0;
    while (tx_q.size() < exp.size() && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (30) @(posedge clk);
    check({tag, "_count"}, tx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < tx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), tx_q[i], exp[i]);
    tx_q.delete();
  endtask

  // Frame-level model: computes response and RAM effect from command semantics.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [15:0] a16,
                           input int len, input logic [7:0] fillv, input logic [7:0] data[$]);
    logic [7:0]  fr[$];
    logic [7:0]  resp[$];
    logic [15:0] l16;
    logic [7:0]  s;
    int          a;
    a   = int'(a16) % MEM;
    l16 = 16'(len);
    s   = 8'h00;
    fr  = {cmd, a16[15:8], a16[7:0], l16[15:8], l16[7:0]};
    if (cmd == 8'h03) fr.push_back(fillv);
    if (cmd == 8'h01) foreach (data[i]) fr.push_back(data[i]);
    for (int i = 0; i < len; i++) begin
      case (cmd)
        8'h01: begin ref_ram[(a + i) % MEM] = data[i]; s += data[i]; end
        8'h02: begin resp.push_back(ref_ram[(a + i) % MEM]); s += ref_ram[(a + i) % MEM]; end
        default: begin ref_ram[(a + i) % MEM] = fillv; s += fillv; end
      endcase
    end
    resp.push_back(8'h06);
    resp.push_back(s);
    wlog_addr.delete();
    wlog_cyc.delete();
    foreach (fr[i]) send_byte(fr[i]);
    expect_resp(tag, resp);
    if (cmd != 8'h02) begin
      check({tag, "_nwrites"}, wlog_addr.size(), len);
      for (int i = 0; i < len && i < wlog_addr.size(); i++) begin
        check($sformatf("%s_waddr%0d", tag, i), wlog_addr[i], (a + i) % MEM);
        if (cmd == 8'h03 && i > 0)
          check($sformatf("%s_wgap%0d", tag, i), wlog_cyc[i] - wlog_cyc[i-1], 1);
      end
    end else begin
      check({tag, "_nowrites"}, wlog_addr.size(), 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start, 1'b0);
    check({tag, "_tx_byte"}, tx_byte, 8'h00);
    check({tag, "_mem_we"}, mem_we, 1'b0);
    check({tag, "_mem_waddr"}, mem_waddr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 8'h00);
    check({tag, "_mem_raddr"}, mem_raddr, 0);
    check({tag, "_mon_owns"}, mon_owns, 1'b1);
    check({tag, "_cpu_reset"}, cpu_reset, 1'b0);
    check({tag, "_cpu_startaddr"}, cpu_startaddr, 0);
  endtask

  initial begin
    logic [7:0] d[$];
    logic [7:0] none[$];
    logic [7:0] r[$];
    int         c0;
    int         t;
    int         bad;

    for (int i = 0; i < MEM; i++) begin
      ram[i]     = 8'($urandom);
      ref_ram[i] = ram[i];
    end

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    d = {8'hAA, 8'h55, 8'h01};
    run_frame("load", 8'h01, 16'h0010, 3, 8'h00, d);
    check("load_ram10", ram[12'h010], 8'hAA);
    check("load_ram12", ram[12'h012], 8'h01);

    run_frame("dump", 8'h02, 16'h0010, 2, 8'h00, none);
    run_frame("fill_wrap", 8'h03, 16'h0FFE, 4, 8'h7E, none);
    check("fill_ram000", ram[0], 8'h7E);

    send_byte(8'h09);
    r = {8'h15};
    expect_resp("badcmd", r);

    c0 = wr_cnt;
    send_byte(8'h01);
    send_byte(8'h00);
    expect_resp("timeout", r);
    check("timeout_no_write", wr_cnt, c0);

    run_frame("load_len0", 8'h01, 16'h0123, 0, 8'h00, none);
    run_frame("dump_len0", 8'h02, 16'h0123, 0, 8'h00, none);
    run_frame("fill_len0", 8'h03, 16'h0123, 0, 8'h33, none);
    d = {8'h11, 8'h22, 8'h33};
    run_frame("load_hibits", 8'h01, 16'hFFFF, 3, 8'h00, d);

    rst_hi = 0;
    send_byte(8'h04);
    send_byte(8'h02);
    send_byte(8'h00);
    repeat (10) @(posedge clk);
    #1;
    check("exec_startaddr", cpu_startaddr, 12'h200);
    check("exec_mon_owns", mon_owns, 1'b0);
    check("exec_reset_len", rst_hi, 2);
    check("exec_reset_low", cpu_reset, 1'b0);
    send_byte(8'h09);
    repeat (20) @(posedge clk);
    check("run_ignores_rx", tx_q.size(), 0);
    @(posedge clk); #1;
    cpu_halted = 1'b1;
    t = 0;
    while (!mon_owns && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    cpu_halted = 1'b0;
    check("halt_mon_owns", mon_owns, 1'b1);
    r = {8'h06, 8'h00};
    expect_resp("halt", r);

    for (int n = 0; n < 30; n++) begin
      int         k;
      int         len;
      logic [7:0] cb;
      k   = $urandom_range(0, 9);
      len = $urandom_range(0, 10);
      d.delete();
      if (k == 9) begin
        cb = 8'($urandom_range(5, 255));
        send_byte(cb);
        r = {8'h15};
        expect_resp($sformatf("rnd%0d_bad", n), r);
      end else begin
        cb = (k < 3) ? 8'h01 : (k < 6) ? 8'h02 : 8'h03;
        for (int i = 0; i < len; i++) d.push_back(8'($urandom));
        run_frame($sformatf("rnd%0d_cmd%0d", n, cb), cb, 16'($urandom), len, 8'($urandom), d);
      end
    end

    bad = 0;
    for (int i = 0; i < MEM; i++) if (ram[i] !== ref_ram[i]) bad++;
    check("ram_image", bad, 0);

    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'd20);
    t = 0;
    while (tx_q.size() < 2 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("middump_started", tx_q.size() >= 2, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    tx_q.delete();
    send_byte(8'h09);
    r = {8'h15};
    expect_resp("after_reset_bad", r);
    run_frame("after_reset_dump", 8'h02, 16'h0FFF, 2, 8'h00, none);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
